// File: rtl/voting_tally_seq_if.sv
// Ballot/result bundle for voting_tally_seq. The tie signal exists only when
// VOTING_TALLY_TIE_EN is defined.
interface voting_tally_seq_if #(
  parameter int unsigned M  = 2,
  parameter int unsigned CW = 8
);
  logic          clear;
  logic          vote_valid;
  logic [M-1:0]  vote_idx;
  logic          vote_ready;
  logic          close;
  logic          busy;
  logic          winner_valid;
  logic [M-1:0]  winner;
  logic [CW-1:0] winner_count;
  logic          overflow;
`ifdef VOTING_TALLY_TIE_EN
  logic          tie;

  modport master (
    output clear, vote_valid, vote_idx, close,
    input  vote_ready, busy, winner_valid, winner, winner_count, overflow, tie
  );

  modport slave (
    input  clear, vote_valid, vote_idx, close,
    output vote_ready, busy, winner_valid, winner, winner_count, overflow, tie
  );
`else
  modport master (
    output clear, vote_valid, vote_idx, close,
    input  vote_ready, busy, winner_valid, winner, winner_count, overflow
  );

  modport slave (
    input  clear, vote_valid, vote_idx, close,
    output vote_ready, busy, winner_valid, winner, winner_count, overflow
  );
`endif
endinterface

// File: rtl/voting_tally_seq.sv
// Sequential plurality vote tally: one saturating counter per candidate, a linear
// scan on close, lowest-index tie-break. Optional tie output under VOTING_TALLY_TIE_EN.
module voting_tally_seq #(
  parameter int unsigned M  = 2,
  parameter int unsigned CW = 8
) (
  input logic               clk,
  input logic               rst_n,
  voting_tally_seq_if.slave bus
);

  localparam int unsigned NC = 2 ** M;
  localparam logic [CW-1:0] CntMax = '1;

  typedef enum logic [1:0] {StCollect, StScan, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q [NC];
  logic [CW-1:0] cnt_d [NC];
  logic [M-1:0]  idx_q, idx_d;
  logic [M-1:0]  best_idx_q, best_idx_d;
  logic [CW-1:0] best_cnt_q, best_cnt_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cur_cnt;
`ifdef VOTING_TALLY_TIE_EN
  logic          tie_q, tie_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StCollect;
      for (int unsigned k = 0; k < NC; k++) cnt_q[k] <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      ovf_q      <= 1'b0;
`ifdef VOTING_TALLY_TIE_EN
      tie_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      ovf_q      <= ovf_d;
`ifdef VOTING_TALLY_TIE_EN
      tie_q      <= tie_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    ovf_d      = ovf_q;
    cur_cnt    = cnt_q[idx_q];
`ifdef VOTING_TALLY_TIE_EN
    tie_d      = tie_q;
`endif

    // clear wins over any vote or close presented in the same cycle
    if (bus.clear) begin
      state_d    = StCollect;
      for (int unsigned k = 0; k < NC; k++) cnt_d[k] = '0;
      idx_d      = '0;
      best_idx_d = '0;
      best_cnt_d = '0;
      ovf_d      = 1'b0;
`ifdef VOTING_TALLY_TIE_EN
      tie_d      = 1'b0;
`endif
    end else begin
      case (state_q)
        StCollect: begin
          if (bus.vote_valid) begin
            if (cnt_q[bus.vote_idx] == CntMax) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d[bus.vote_idx] = cnt_q[bus.vote_idx] + 1'b1;
            end
          end
          if (bus.close) begin
            state_d = StScan;
            idx_d   = '0;
          end
        end

        StScan: begin
          if (idx_q == '0) begin
            best_idx_d = '0;
            best_cnt_d = cur_cnt;
`ifdef VOTING_TALLY_TIE_EN
            tie_d      = 1'b0;
`endif
          end else if (cur_cnt > best_cnt_q) begin
            // strictly greater only, so equal counts keep the lower index
            best_idx_d = idx_q;
            best_cnt_d = cur_cnt;
`ifdef VOTING_TALLY_TIE_EN
            tie_d      = 1'b0;
`endif
          end else if (cur_cnt == best_cnt_q) begin
`ifdef VOTING_TALLY_TIE_EN
            tie_d      = 1'b1;
`endif
          end
          idx_d = idx_q + 1'b1;
          if (&idx_q) state_d = StDone;
        end

        StDone: begin
          state_d = StDone;
        end

        default: begin
          state_d = StCollect;
        end
      endcase
    end
  end

  // Results are forced to zero outside DONE so they never expose partial scans.
  always_comb begin
    bus.vote_ready   = (state_q == StCollect);
    bus.busy         = (state_q == StScan);
    bus.winner_valid = (state_q == StDone);
    bus.winner       = (state_q == StDone) ? best_idx_q : '0;
    bus.winner_count = (state_q == StDone) ? best_cnt_q : '0;
    bus.overflow     = ovf_q;
`ifdef VOTING_TALLY_TIE_EN
    bus.tie          = (state_q == StDone) ? tie_q : 1'b0;
`endif
  end

endmodule
